// File: rtl/fifo_rx_sink_pkg.sv
// Shared types for the parity-FIFO read-side sink: bandwidth select, grant FSM
// states and the random-grant LFSR definition.
package fifo_tb_pkg;

   // Bandwidth select driven by the bench's bandwidth control
   typedef enum logic [1:0] {
      BW_000  = 2'd0,
      BW_050  = 2'd1,
      BW_100  = 2'd2,
      BW_RAND = 2'd3
   } grant_in_e;

   // Grant pattern FSM states
   typedef enum logic [2:0] {
      G_OFF    = 3'd0,
      G_ON     = 3'd1,
      G_ALT_HI = 3'd2,
      G_ALT_LO = 3'd3,
      G_RAND   = 3'd4
   } grant_state_e;

   localparam int unsigned LFSR_WIDTH = 8;

   // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
   localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'b1011_1000;

   // One Fibonacci step: shift toward the MSB, feedback enters at bit 0
   function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
      return {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage : fifo_tb_pkg

// File: rtl/fifo_rx_sink_grant.sv
// grant_pattern_gen: registered read-grant pattern generator.
// Optional macro FIFO_RX_LFSR_BW_EN builds the random-grant LFSR; without it
// BW_RAND behaves like BW_100.
module grant_pattern_gen
   import fifo_tb_pkg::*;
#(
   parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = 8'hA5
) (
   input  logic      clk,
   input  logic      rst,
   input  grant_in_e bw_mode,
   output logic      grant_in
);

   grant_state_e r_state;
   logic         r_grant;

`ifdef FIFO_RX_LFSR_BW_EN
   logic [LFSR_WIDTH-1:0] r_lfsr;
   logic [LFSR_WIDTH-1:0] w_lfsr_nxt;

   // LFSR only moves while the FSM sits in the random state
   assign w_lfsr_nxt = (r_state == G_RAND) ? lfsr_step(r_lfsr) : r_lfsr;

   // Random-grant LFSR register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= w_lfsr_nxt;
      end
   end
`else
   logic w_unused_seed;

   // Seed has no effect when the LFSR is not built
   assign w_unused_seed = ^LFSR_SEED;
`endif

   // Grant FSM; grant output is registered alongside the state it belongs to
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= G_OFF;
         r_grant <= 1'b0;
      end else begin
         case (bw_mode)
            BW_000: begin
               r_state <= G_OFF;
               r_grant <= 1'b0;
            end
            BW_050: begin
               if (r_state == G_ALT_HI) begin
                  r_state <= G_ALT_LO;
                  r_grant <= 1'b0;
               end else begin
                  r_state <= G_ALT_HI;
                  r_grant <= 1'b1;
               end
            end
            BW_100: begin
               r_state <= G_ON;
               r_grant <= 1'b1;
            end
            BW_RAND: begin
`ifdef FIFO_RX_LFSR_BW_EN
               r_state <= G_RAND;
               r_grant <= w_lfsr_nxt[0];
`else
               r_state <= G_ON;
               r_grant <= 1'b1;
`endif
            end
            default: begin
               r_state <= G_OFF;
               r_grant <= 1'b0;
            end
         endcase
      end
   end

   assign grant_in = r_grant;

endmodule : grant_pattern_gen

// File: rtl/fifo_rx_sink.sv
// fifo_rx_sink: read-side consumer of the parity FIFO. Drives a patterned
// grant, accepts words on valid_out && grant_in, checks even parity and keeps
// saturating received/error counters.
// Optional macro FIFO_RX_LFSR_BW_EN enables the random-grant pattern.
module fifo_rx_sink
   import fifo_tb_pkg::*;
#(
   parameter int unsigned             DATA_WIDTH  = 17,
   parameter int unsigned             COUNT_WIDTH = 16,
   parameter logic [LFSR_WIDTH-1:0]   LFSR_SEED   = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  grant_in_e              bw_mode,
   input  logic                   valid_out,
   input  logic [DATA_WIDTH-1:0]  data_out,
   output logic                   grant_in,
   output logic [DATA_WIDTH-2:0]  rx_data,
   output logic                   rx_valid,
   output logic                   par_err,
   output logic [COUNT_WIDTH-1:0] rx_count,
   output logic [COUNT_WIDTH-1:0] err_count
);

   localparam int unsigned            PAY_W   = DATA_WIDTH - 1;
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   logic                   w_grant;
   logic                   w_accept;
   logic                   w_par_bad;
   logic [PAY_W-1:0]       r_rx_data;
   logic                   r_rx_valid;
   logic                   r_par_err;
   logic [COUNT_WIDTH-1:0] r_rx_count;
   logic [COUNT_WIDTH-1:0] r_err_count;

   grant_pattern_gen #(
      .LFSR_SEED (LFSR_SEED)
   ) u_grant (
      .clk      (clk),
      .rst      (rst),
      .bw_mode  (bw_mode),
      .grant_in (w_grant)
   );

   // Accept uses the grant already on the wire, not the one being computed
   assign w_accept  = valid_out & w_grant;
   // Even parity over the full word: any odd bit count is an error
   assign w_par_bad = ^data_out;

   // Capture payload and produce the one-cycle result pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_par_err  <= 1'b0;
      end else begin
         r_rx_valid <= w_accept;
         r_par_err  <= w_accept & w_par_bad;
         if (w_accept) begin
            r_rx_data <= data_out[PAY_W-1:0];
         end
      end
   end

   // Saturating received-word and parity-error counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_count  <= '0;
         r_err_count <= '0;
      end else if (w_accept) begin
         if (r_rx_count != CNT_MAX) begin
            r_rx_count <= r_rx_count + COUNT_WIDTH'(1);
         end
         if (w_par_bad && (r_err_count != CNT_MAX)) begin
            r_err_count <= r_err_count + COUNT_WIDTH'(1);
         end
      end
   end

   assign grant_in  = w_grant;
   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign par_err   = r_par_err;
   assign rx_count  = r_rx_count;
   assign err_count = r_err_count;

endmodule : fifo_rx_sink

// File: doc/fifo_rx_sink.md
# fifo_rx_sink

Synthesizable consumer for the read side of the parity FIFO. It drives `grant_in` with a selectable bandwidth pattern and accepts words on `valid_out && grant_in`. Each accepted word gets a parity check, and the block keeps received-word and parity-error counters. It is the counterpart of the write-side traffic generator: the bench's bandwidth control enum drives `bw_mode` directly.

## Interface
- `DATA_WIDTH`, 17: FIFO word width. Bit `DATA_WIDTH-1` is parity; bits `DATA_WIDTH-2:0` are payload.
- `COUNT_WIDTH`, 16: width of both counters.
- `LFSR_SEED`, 8'hA5: reset value of the random-grant LFSR. Must be nonzero.

Ports (clock and reset first):
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `bw_mode`  in  `grant_in_e` (2): bandwidth select. `BW_000`=0, `BW_050`=1, `BW_100`=2, `BW_RAND`=3.
- `valid_out`  in  1: the FIFO presents a word.
- `data_out`  in  `DATA_WIDTH`: the FIFO word.
- `grant_in`  out  1: registered read grant to the FIFO.
- `rx_data`  out  `DATA_WIDTH-1`: payload of the last accepted word.
- `rx_valid`  out  1: one-cycle pulse, asserted the cycle after an accept.
- `par_err`  out  1: one-cycle pulse, coincident with `rx_valid`, when the accepted word fails parity.
- `rx_count`  out  `COUNT_WIDTH`: number of accepted words.
- `err_count`  out  `COUNT_WIDTH`: number of parity failures.

## Operation
- **Accept:** a word is accepted at a rising edge where `valid_out`=1 and `grant_in`=1 (the registered value). No other condition applies.
- **Parity:** even. The word is good when the XOR of all `DATA_WIDTH` bits of `data_out` is 0.
- **On accept:**
  - `rx_data` takes the payload.
  - `rx_count` increments by 1.
  - `err_count` increments by 1 if the word fails parity.
  - Both counters saturate at all-ones; they never wrap.
- **Grant FSM** (inside `grant_pattern_gen`), states `G_OFF`, `G_ON`, `G_ALT_HI`, `G_ALT_LO`, `G_RAND`. `grant_in` is 1 in `G_ON`, `G_ALT_HI`, and in `G_RAND` when LFSR bit 0 is 1.
  - `bw_mode`=`BW_000` → next state `G_OFF`.
  - `BW_100` → `G_ON`.
  - `BW_050`:
    - `G_ALT_HI` ↔ `G_ALT_LO` alternate every cycle.
    - Entry from any other state goes to `G_ALT_HI`.
  - `BW_RAND` → `G_RAND`. The LFSR advances every cycle in this state and holds otherwise.
    - LFSR: 8-bit Fibonacci, taps 8,6,5,4.
- **Mode changes:** sampled every edge. The new pattern appears on `grant_in` at the next edge. Words already accepted are unaffected.
- **Simultaneous events:** a grant edge and an accept on the same edge are legal. The accept uses the old `grant_in` value.

## Timing
- **Reset values:**
  - FSM in `G_OFF`, so `grant_in`=0.
  - `rx_data`=0, `rx_valid`=0, `par_err`=0, `rx_count`=0, `err_count`=0.
  - LFSR=`LFSR_SEED`.
- **Reset mid-operation:** all outputs clear immediately (asynchronous), and any in-flight accept is dropped.
- **Release:** on the first edge after `rst` falls, the FSM evaluates `bw_mode`. `grant_in` is therefore 1 no earlier than that edge.
- **Latency:** accept at edge k. At edge k, `rx_data`, `rx_valid`, `par_err`, and both counters update together; the pulses are high for the cycle k to k+1.
- **Throughput:**
  - `BW_100`: one word per cycle.
  - `BW_050`: exactly one grant every 2 cycles.
  - `BW_000`: nothing is accepted; the FIFO fills.

## Configuration
- **`FIFO_RX_LFSR_BW_EN` defined:** `BW_RAND` selects `G_RAND` and the LFSR is instantiated.
- **`FIFO_RX_LFSR_BW_EN` undefined:** `BW_RAND` maps to `G_ON` (same as `BW_100`), no LFSR is built, and `LFSR_SEED` is ignored.

## Structure
- `fifo_tb_pkg` holds:
  - the `grant_in_e` enum, extended with `BW_RAND`=3;
  - the `grant_state_e` FSM enum;
  - the LFSR width and tap constant.
- Sub-module `grant_pattern_gen`:
  - ports: `clk`, `rst`, `bw_mode`, `grant_in`;
  - contains the FSM and the LFSR.
- Top level holds the accept logic, the parity check, and the counters.

## Test plan
- **Reset release:** hold `rst` 3 cycles with `bw_mode`=`BW_100` and `valid_out`=1 → `grant_in`=0 during reset. After release, `grant_in`=1 from the first edge, and `rx_count` reaches 4 after 4 more edges.
- **Parity check:** `BW_100`, send 0x0_0001 (bad), 0x1_0001 (good), 0x0_0003 (good) → `rx_count`=3, `err_count`=1. `par_err` pulses only for the first word; `rx_data` ends at 0x0003.
- **50% pattern:** `BW_050` for 10 cycles with `valid_out` held 1 → `grant_in` alternates 1,0,1,0…, starting at 1 on the first edge after the mode change, and `rx_count`=5.
- **Stall and full:** `BW_000` for 8 cycles with `valid_out`=1 → `grant_in`=0 and `rx_count` unchanged. Then switch to `BW_100` → accepts resume one edge later.
- **Saturation:** `COUNT_WIDTH`=4, 20 bad-parity words → `rx_count`=15 and `err_count`=15, held.
- **Random grant and reset mid-burst:**
  - with `FIFO_RX_LFSR_BW_EN`, `BW_RAND` → `grant_in` matches the LFSR bit-0 sequence from seed 0xA5;
  - without the macro, `BW_RAND` → `grant_in` is constantly 1;
  - asserting `rst` mid-burst → all counters read 0 in the same cycle.
